// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART constants and receiver state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int CLK_HZ             = 50_000_000;
    localparam int BAUD               = 57600;
    localparam int CLKS_PER_BIT_57600 = 868;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Serial line, holding-register handshake and status bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_serial;
    logic                 rx_ack;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_full;
    logic                 rx_valid;
    logic                 rx_frame_err;
    logic                 rx_overrun;
    logic                 rx_busy;

    modport master (
        input  rx_serial, rx_ack,
        output rx_data, rx_full, rx_valid, rx_frame_err, rx_overrun, rx_busy
    );

    modport slave (
        output rx_serial, rx_ack,
        input  rx_data, rx_full, rx_valid, rx_frame_err, rx_overrun, rx_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bit_timer
// Description : Reloadable down-counter with a one-cycle terminal tick.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_load,
    output logic             o_tick
);
    logic [WIDTH-1:0] r_count;

    // Clear holds the counter parked, so no tick can escape while idle.
    assign o_tick = !i_clear && (r_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear || o_tick) begin
            r_count <= i_load;
        end else begin
            r_count <= r_count - 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with one-entry holding register and status.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_57600,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2,
    parameter int DATA_BITS    = 8
) (
    input  logic     CLOCK_50,
    input  logic     reset,
    uart_rx_if.master rx
);
    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam int c_idx_w = $clog2(DATA_BITS + 1);

    // The timer ticks on the cycle its count reaches zero, so loads are N-1.
    localparam logic [c_cnt_w-1:0] c_bit_load  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_half_load = c_cnt_w'(HALF_BIT - 1);
    localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(DATA_BITS - 1);

    logic                 r_sync1;
    logic                 r_rx_s;
    uart_state_e          r_state;
    uart_state_e          w_state_next;
    logic [c_idx_w-1:0]   r_index;
    logic [DATA_BITS-1:0] r_shift;
    logic                 w_tick;
    logic                 w_clear;
    logic [c_cnt_w-1:0]   w_load;
    logic                 w_write;
    logic                 w_frame_err;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx.rx_serial;
            r_rx_s  <= r_sync1;
        end
    end

    assign w_clear = (r_state == IDLE) || (r_state == WAIT_IDLE);
    assign w_load  = (w_state_next == START) ? c_half_load : c_bit_load;

    uart_bit_timer #(
        .WIDTH (c_cnt_w)
    ) u_bit_timer (
        .clk     (CLOCK_50),
        .rst     (reset),
        .i_clear (w_clear),
        .i_load  (w_load),
        .o_tick  (w_tick)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_write      = 1'b0;
        w_frame_err  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_rx_s) w_state_next = START;
            end
            START: begin
                if (w_tick) w_state_next = r_rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (w_tick && (r_index == c_last_idx)) w_state_next = STOP;
            end
            STOP: begin
                if (w_tick) begin
                    if (r_rx_s) begin
                        w_write      = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_frame_err  = 1'b1;
                        w_state_next = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // A held-low line (break) must not be mistaken for a new start.
                if (r_rx_s) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_index <= '0;
            r_shift <= '0;
        end else if (r_state == START) begin
            r_index <= '0;
        end else if ((r_state == DATA) && w_tick) begin
            r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            r_index <= r_index + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rx.rx_data      <= '0;
            rx.rx_full      <= 1'b0;
            rx.rx_valid     <= 1'b0;
            rx.rx_frame_err <= 1'b0;
            rx.rx_overrun   <= 1'b0;
        end else begin
            rx.rx_valid     <= w_write;
            rx.rx_frame_err <= w_frame_err;
            // A new byte beats a simultaneous ack: the holding register stays full.
            if (w_write) begin
                rx.rx_data <= r_shift;
                rx.rx_full <= 1'b1;
            end else if (rx.rx_ack && rx.rx_full) begin
                rx.rx_full <= 1'b0;
            end
            if (w_write && rx.rx_full && !rx.rx_ack) begin
                rx.rx_overrun <= 1'b1;
            end else if (rx.rx_ack && rx.rx_full) begin
                rx.rx_overrun <= 1'b0;
            end
        end
    end

    assign rx.rx_busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Randomised self-checking bench for uart_rx (fast and 57600 baud).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int CPB     = 16;
    localparam int HB      = 8;
    localparam int DB      = 8;
    localparam int CPB_DEF = 868;
    localparam int HB_DEF  = 434;
    // Two synchroniser flops plus the IDLE detection edge.
    localparam int LAT     = 3;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    uart_rx_if #(.DATA_BITS(DB)) bus ();
    uart_rx_if #(.DATA_BITS(DB)) bus_d ();

    uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(HB), .DATA_BITS(DB)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .rx       (bus)
    );

    uart_rx dut_def (
        .CLOCK_50 (clk),
        .reset    (rst),
        .rx       (bus_d)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int valid_cnt = 0, ferr_cnt = 0, last_valid_cyc = 0;
    int valid_cnt_d = 0, last_valid_cyc_d = 0;
    logic [7:0] got_q[$];

    logic [7:0] m_data;
    logic       m_full;
    logic       m_ovr;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
            got_q.push_back(bus.rx_data);
        end
        if (bus.rx_frame_err) ferr_cnt <= ferr_cnt + 1;
        if (bus_d.rx_valid) begin
            valid_cnt_d      <= valid_cnt_d + 1;
            last_valid_cyc_d <= cyc;
        end
    end

    // ---------------- reference model of the holding register ----------------
    task automatic model_frame(input logic [7:0] b, input bit ack);
        if (m_full && !ack) m_ovr = 1'b1;
        else if (m_full && ack) m_ovr = 1'b0;
        m_data = b;
        m_full = 1'b1;
    endtask

    task automatic model_ack();
        if (m_full) begin
            m_full = 1'b0;
            m_ovr  = 1'b0;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) bus_d.rx_serial = v;
        else     bus.rx_serial   = v;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop,
                              input int stop_bits, input bit release_line, output int t_start);
        int p;
        p = sel ? CPB_DEF : CPB;
        t_start = cyc;
        drive(sel, 1'b0);
        step(p);
        for (int i = 0; i < DB; i++) begin
            drive(sel, b[i]);
            step(p);
        end
        drive(sel, stop);
        step(p * stop_bits);
        if (release_line) drive(sel, 1'b1);
    endtask

    task automatic ack_pulse();
        bus.rx_ack = 1'b1;
        step(1);
        bus.rx_ack = 1'b0;
        model_ack();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.rx_serial = 1'b1; bus.rx_ack = 1'b0;
        bus_d.rx_serial = 1'b1; bus_d.rx_ack = 1'b0;
        step(3);
        m_data = '0; m_full = 1'b0; m_ovr = 1'b0;
        n_checks++; if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", bus.rx_data); end
        n_checks++; if (bus.rx_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", bus.rx_full); end
        n_checks++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.rx_valid); end
        n_checks++; if (bus.rx_frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", bus.rx_frame_err); end
        n_checks++; if (bus.rx_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", bus.rx_overrun); end
        n_checks++; if (bus.rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.rx_busy); end
        rst = 1'b0;
        step(4);
    endtask

    task automatic test_good_frame();
        int v0, f0, t0;
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(0, 8'h41, 1'b1, 1, 1, t0);
        step(2);
        model_frame(8'h41, 0);
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL good_valid_count: got %0d expected 1", valid_cnt - v0); end
        n_checks++; if (last_valid_cyc !== t0 + LAT + HB + 9 * CPB) begin n_fail++; $display("FAIL good_valid_time: got %0d expected %0d", last_valid_cyc - t0, LAT + HB + 9 * CPB); end
        n_checks++; if (bus.rx_data !== m_data) begin n_fail++; $display("FAIL good_data: got %h expected %h", bus.rx_data, m_data); end
        n_checks++; if (bus.rx_full !== 1'b1) begin n_fail++; $display("FAIL good_full: got %b expected 1", bus.rx_full); end
        n_checks++; if (bus.rx_overrun !== 1'b0) begin n_fail++; $display("FAIL good_ovr: got %b expected 0", bus.rx_overrun); end
        n_checks++; if (ferr_cnt !== f0) begin n_fail++; $display("FAIL good_ferr: got %0d expected %0d", ferr_cnt, f0); end
        n_checks++; if (bus.rx_busy !== 1'b0) begin n_fail++; $display("FAIL good_busy: got %b expected 0", bus.rx_busy); end
        ack_pulse();
        step(1);
        n_checks++; if (bus.rx_full !== 1'b0) begin n_fail++; $display("FAIL good_ack_full: got %b expected 0", bus.rx_full); end
    endtask

    task automatic test_glitch();
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        drive(0, 1'b0);
        step(4);
        drive(0, 1'b1);
        n_checks++; if (bus.rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_high: got %b expected 1", bus.rx_busy); end
        step(2 * CPB);
        n_checks++; if (bus.rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_low: got %b expected 0", bus.rx_busy); end
        n_checks++; if (valid_cnt !== v0) begin n_fail++; $display("FAIL glitch_valid: got %0d expected %0d", valid_cnt, v0); end
        n_checks++; if (ferr_cnt !== f0) begin n_fail++; $display("FAIL glitch_ferr: got %0d expected %0d", ferr_cnt, f0); end
        n_checks++; if (bus.rx_full !== m_full) begin n_fail++; $display("FAIL glitch_full: got %b expected %b", bus.rx_full, m_full); end
    endtask

    task automatic test_frame_error();
        int v0, f0, t0;
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(0, 8'h55, 1'b0, 3, 0, t0);
        n_checks++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_count: got %0d expected 1", ferr_cnt - f0); end
        n_checks++; if (valid_cnt !== v0) begin n_fail++; $display("FAIL ferr_valid: got %0d expected %0d", valid_cnt, v0); end
        n_checks++; if (bus.rx_data !== m_data) begin n_fail++; $display("FAIL ferr_data: got %h expected %h", bus.rx_data, m_data); end
        n_checks++; if (bus.rx_full !== m_full) begin n_fail++; $display("FAIL ferr_full: got %b expected %b", bus.rx_full, m_full); end
        n_checks++; if (bus.rx_busy !== 1'b1) begin n_fail++; $display("FAIL ferr_wait_busy: got %b expected 1", bus.rx_busy); end
        drive(0, 1'b1);
        step(4);
        n_checks++; if (bus.rx_busy !== 1'b0) begin n_fail++; $display("FAIL ferr_release_busy: got %b expected 0", bus.rx_busy); end
        send_frame(0, 8'h3C, 1'b1, 1, 1, t0);
        step(2);
        model_frame(8'h3C, 0);
        n_checks++; if (bus.rx_data !== m_data) begin n_fail++; $display("FAIL ferr_next_data: got %h expected %h", bus.rx_data, m_data); end
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL ferr_next_valid: got %0d expected 1", valid_cnt - v0); end
        ack_pulse();
    endtask

    task automatic test_overrun_handshake();
        int t0, ts, v0;
        send_frame(0, 8'h12, 1'b1, 1, 1, t0);
        model_frame(8'h12, 0);
        send_frame(0, 8'hA5, 1'b1, 1, 1, t0);
        model_frame(8'hA5, 0);
        step(2);
        n_checks++; if (bus.rx_data !== m_data) begin n_fail++; $display("FAIL ovr_data: got %h expected %h", bus.rx_data, m_data); end
        n_checks++; if (bus.rx_overrun !== m_ovr) begin n_fail++; $display("FAIL ovr_set: got %b expected %b", bus.rx_overrun, m_ovr); end
        n_checks++; if (bus.rx_full !== m_full) begin n_fail++; $display("FAIL ovr_full: got %b expected %b", bus.rx_full, m_full); end
        ack_pulse();
        n_checks++; if (bus.rx_full !== 1'b0) begin n_fail++; $display("FAIL ack_full: got %b expected 0", bus.rx_full); end
        n_checks++; if (bus.rx_overrun !== 1'b0) begin n_fail++; $display("FAIL ack_ovr: got %b expected 0", bus.rx_overrun); end
        ack_pulse();
        n_checks++; if (bus.rx_data !== m_data) begin n_fail++; $display("FAIL idle_ack_data: got %h expected %h", bus.rx_data, m_data); end
        n_checks++; if (bus.rx_full !== m_full) begin n_fail++; $display("FAIL idle_ack_full: got %b expected %b", bus.rx_full, m_full); end
        send_frame(0, 8'h12, 1'b1, 1, 1, t0);
        model_frame(8'h12, 0);
        v0 = valid_cnt;
        ts = cyc;
        fork
            send_frame(0, 8'hA5, 1'b1, 1, 1, t0);
            begin
                // Ack lands on the same edge that writes the new byte.
                step(LAT - 1 + HB + 9 * CPB);
                bus.rx_ack = 1'b1;
                step(1);
                bus.rx_ack = 1'b0;
            end
        join
        model_frame(8'hA5, 1);
        step(2);
        n_checks++; if (last_valid_cyc !== ts + LAT + HB + 9 * CPB) begin n_fail++; $display("FAIL ackwrite_time: got %0d expected %0d", last_valid_cyc - ts, LAT + HB + 9 * CPB); end
        n_checks++; if (bus.rx_full !== m_full) begin n_fail++; $display("FAIL ackwrite_full: got %b expected %b", bus.rx_full, m_full); end
        n_checks++; if (bus.rx_overrun !== m_ovr) begin n_fail++; $display("FAIL ackwrite_ovr: got %b expected %b", bus.rx_overrun, m_ovr); end
        n_checks++; if (bus.rx_data !== m_data) begin n_fail++; $display("FAIL ackwrite_data: got %h expected %h", bus.rx_data, m_data); end
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL ackwrite_valid: got %0d expected 1", valid_cnt - v0); end
    endtask

    task automatic test_reset_mid_frame();
        int t0, v0;
        v0 = valid_cnt;
        fork
            send_frame(0, 8'hFF, 1'b1, 1, 1, t0);
            begin
                // Lands inside the data bit 4 sampling window.
                step(LAT + HB + 4 * CPB + 5);
                rst = 1'b1;
                step(1);
                m_data = '0; m_full = 1'b0; m_ovr = 1'b0;
                n_checks++; if (bus.rx_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h expected 00", bus.rx_data); end
                n_checks++; if (bus.rx_full !== 1'b0) begin n_fail++; $display("FAIL midrst_full: got %b expected 0", bus.rx_full); end
                n_checks++; if (bus.rx_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bus.rx_busy); end
                n_checks++; if (bus.rx_overrun !== 1'b0) begin n_fail++; $display("FAIL midrst_ovr: got %b expected 0", bus.rx_overrun); end
                rst = 1'b0;
            end
        join
        step(2);
        n_checks++; if (valid_cnt !== v0) begin n_fail++; $display("FAIL midrst_valid: got %0d expected %0d", valid_cnt, v0); end
        send_frame(0, 8'h00, 1'b1, 1, 1, t0);
        model_frame(8'h00, 0);
        step(2);
        n_checks++; if (bus.rx_full !== m_full) begin n_fail++; $display("FAIL midrst_next_full: got %b expected %b", bus.rx_full, m_full); end
        n_checks++; if (bus.rx_data !== m_data) begin n_fail++; $display("FAIL midrst_next_data: got %h expected %h", bus.rx_data, m_data); end
        n_checks++; if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL midrst_next_valid: got %0d expected 1", valid_cnt - v0); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int t0;
        got_q.delete();
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_frame(0, b, 1'b1, 1, 1, t0);
            model_frame(b, 0);
        end
        step(4);
        n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (bus.rx_overrun !== m_ovr) begin n_fail++; $display("FAIL b2b_ovr: got %b expected %b", bus.rx_overrun, m_ovr); end
        n_checks++; if (bus.rx_data !== m_data) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", bus.rx_data, m_data); end
    endtask

    task automatic test_random_ack();
        logic [7:0] b;
        int t0;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            send_frame(0, b, 1'b1, 1, 1, t0);
            model_frame(b, 0);
            step(2);
            if ($urandom_range(0, 1) == 1) ack_pulse();
            step(1);
            n_checks++; if (bus.rx_data !== m_data) begin n_fail++; $display("FAIL rnd_data%0d: got %h expected %h", i, bus.rx_data, m_data); end
            n_checks++; if (bus.rx_full !== m_full) begin n_fail++; $display("FAIL rnd_full%0d: got %b expected %b", i, bus.rx_full, m_full); end
            n_checks++; if (bus.rx_overrun !== m_ovr) begin n_fail++; $display("FAIL rnd_ovr%0d: got %b expected %b", i, bus.rx_overrun, m_ovr); end
        end
    endtask

    task automatic test_default_rate();
        logic [7:0] b;
        int t0, v0;
        b = 8'($urandom);
        v0 = valid_cnt_d;
        send_frame(1, b, 1'b1, 1, 1, t0);
        step(2);
        n_checks++; if (valid_cnt_d - v0 !== 1) begin n_fail++; $display("FAIL def_valid_count: got %0d expected 1", valid_cnt_d - v0); end
        n_checks++; if (last_valid_cyc_d !== t0 + LAT + HB_DEF + 9 * CPB_DEF) begin n_fail++; $display("FAIL def_valid_time: got %0d expected %0d", last_valid_cyc_d - t0, LAT + HB_DEF + 9 * CPB_DEF); end
        n_checks++; if (bus_d.rx_data !== b) begin n_fail++; $display("FAIL def_data: got %h expected %h", bus_d.rx_data, b); end
        n_checks++; if (bus_d.rx_full !== 1'b1) begin n_fail++; $display("FAIL def_full: got %b expected 1", bus_d.rx_full); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_glitch();
        test_frame_error();
        test_overrun_handshake();
        test_reset_mid_frame();
        test_back_to_back();
        test_random_ack();
        test_default_rate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
